// File: rtl/alu_exec.sv
// Two-stage ALU execute unit with valid/ready handshakes on both sides.
// S1 registers the request, S2 registers the computed result and flags.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       gout,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             taken,
    output logic             ovf,
    output logic             illegal,
    output logic [15:0]      op_count
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SLT  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_OR   = 4'b0100,
        OP_AND  = 4'b1000,
        OP_NOR  = 4'b1001,
        OP_BNE  = 4'b1010,
        OP_BGEZ = 4'b1011,
        OP_BGTZ = 4'b1100,
        OP_BLEZ = 4'b1101,
        OP_BLTZ = 4'b1110
    } op_e;

    localparam int MSB = WIDTH - 1;

    logic             s1_valid;
    logic [3:0]       s1_gout;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s1_adv;
    logic             accept;
    logic             consume;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             a_neg;
    logic             a_zero;

    logic [WIDTH-1:0] nxt_result;
    logic             nxt_zero;
    logic             nxt_taken;
    logic             nxt_ovf;
    logic             nxt_illegal;

    // S1 moves on whenever S2 is free or being drained this very cycle.
    assign consume  = out_valid && out_ready;
    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s1_adv;
    assign accept   = in_valid && in_ready;

    assign sum    = s1_a + s1_b;
    assign diff   = s1_a - s1_b;
    assign a_neg  = s1_a[MSB];
    assign a_zero = (s1_a == '0);

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        nxt_result  = '0;
        nxt_taken   = 1'b0;
        nxt_ovf     = 1'b0;
        nxt_illegal = 1'b0;
        case (s1_gout)
            OP_ADD: begin
                nxt_result = sum;
                nxt_ovf    = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
            end
            OP_SUB: begin
                nxt_result = diff;
                nxt_ovf    = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
            end
            OP_SLT:  nxt_result = WIDTH'($signed(s1_a) < $signed(s1_b));
            OP_OR:   nxt_result = s1_a | s1_b;
            OP_AND:  nxt_result = s1_a & s1_b;
            OP_NOR:  nxt_result = ~(s1_a | s1_b);
            OP_BNE: begin
                nxt_result = diff;
                nxt_taken  = (s1_a != s1_b);
            end
            OP_BGEZ: begin
                nxt_result = diff;
                nxt_taken  = !a_neg;
            end
            OP_BGTZ: begin
                nxt_result = diff;
                nxt_taken  = !a_neg && !a_zero;
            end
            OP_BLEZ: begin
                nxt_result = diff;
                nxt_taken  = a_neg || a_zero;
            end
            OP_BLTZ: begin
                nxt_result = diff;
                nxt_taken  = a_neg;
            end
            default: nxt_illegal = 1'b1;
        endcase
        nxt_zero = (nxt_result == '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // NOTE: the S1 payload is not reset; it is only ever observed while s1_valid is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_gout <= gout;
            s1_a    <= a;
            s1_b    <= b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            taken     <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            result    <= nxt_result;
            zero      <= nxt_zero;
            taken     <= nxt_taken;
            ovf       <= nxt_ovf;
            illegal   <= nxt_illegal;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (consume) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed vector table, stall/reset sequences, and a
// randomized stream scored against an arithmetic reference model.
module tb_alu_exec;

    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        taken;
        logic        ovf;
        logic        illegal;
    } resp_t;

    typedef struct {
        logic [3:0]  g;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        t;
        logic        o;
        logic        i;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  gout;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        taken;
    logic        ovf;
    logic        illegal;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_errors = 0;

    resp_t       exp_q[$];
    logic [15:0] exp_opc = '0;
    logic        stall_pending = 1'b0;
    resp_t       held;

    alu_exec #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gout      (gout),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .taken     (taken),
        .ovf       (ovf),
        .illegal   (illegal),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: works on signed integer values and plain set membership.
    function automatic resp_t model(input logic [3:0] g, input logic [31:0] x, input logic [31:0] y);
        resp_t  m;
        longint sx;
        longint sy;
        longint r;
        m  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = sx - sy;
        case (g)
            4'd0: begin
                r = sx + sy;
                m.result = r[31:0];
                m.ovf = (r > MAX_S) || (r < MIN_S);
            end
            4'd2: begin
                m.result = r[31:0];
                m.ovf = (r > MAX_S) || (r < MIN_S);
            end
            4'd1:  m.result = (sx < sy) ? 32'd1 : 32'd0;
            4'd4:  m.result = x | y;
            4'd8:  m.result = x & y;
            4'd9:  m.result = ~(x | y);
            4'd10: begin m.result = r[31:0]; m.taken = (x != y); end
            4'd11: begin m.result = r[31:0]; m.taken = (sx >= 0); end
            4'd12: begin m.result = r[31:0]; m.taken = (sx > 0);  end
            4'd13: begin m.result = r[31:0]; m.taken = (sx <= 0); end
            4'd14: begin m.result = r[31:0]; m.taken = (sx < 0);  end
            default: m.illegal = 1'b1;
        endcase
        m.zero = (m.result == 32'd0);
        return m;
    endfunction

    // Scoreboard monitor: samples 1ns after each falling edge, away from the active edge.
    always @(negedge clk) begin
        resp_t cur;
        resp_t exp;
        #1;
        cur = {result, zero, taken, ovf, illegal};
        if (!rst_n) begin
            exp_q.delete();
            exp_opc = '0;
            stall_pending = 1'b0;
            check("mon_reset_out_valid", {63'd0, out_valid}, 64'd0);
            check("mon_reset_in_ready", {63'd0, in_ready}, 64'd1);
        end else begin
            check("mon_op_count", {48'd0, op_count}, {48'd0, exp_opc});
            if (stall_pending) begin
                check("mon_hold_valid", {63'd0, out_valid}, 64'd1);
                check("mon_hold_data", {28'd0, cur}, {28'd0, held});
            end
            stall_pending = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("mon_unexpected_response", 64'd1, 64'd0);
                    end else begin
                        exp = exp_q.pop_front();
                        check("mon_response", {28'd0, cur}, {28'd0, exp});
                    end
                    exp_opc = exp_opc + 16'd1;
                end else begin
                    stall_pending = 1'b1;
                    held = cur;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(gout, a, b));
        end
    end

    task automatic send_one(input logic [3:0] g, input logic [31:0] x, input logic [31:0] y,
                            output resp_t r, output int lat);
        int guard;
        @(negedge clk);
        gout = g; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk); #1; lat++;
        end
        r = {result, zero, taken, ovf, illegal};
    endtask

    task automatic stall_burst();
        int sent = 0;
        int got  = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (sent < 4);
            gout      = 4'b0000;
            a         = 32'(100 * (sent + 1));
            b         = 32'(sent + 1);
            #1;
            if (cyc == 2) begin
                check("burst_in_ready_low", {63'd0, in_ready}, 64'd0);
                check("burst_accepts_before_stall", 64'(sent), 64'd2);
            end
            if (cyc >= 2 && cyc <= 4) begin
                check("burst_hold_valid", {63'd0, out_valid}, 64'd1);
                check("burst_hold_result", {32'd0, result}, 64'd101);
            end
            if (out_valid && out_ready) begin
                check("burst_order", {32'd0, result}, 64'(101 * (got + 1)));
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        check("burst_delivered", 64'(got), 64'd4);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t  tbl[17];
        resp_t r;
        int    lat;
        int    acc;
        int    cons;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        gout = '0; a = '0; b = '0;

        #2;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_result", {32'd0, result}, 64'd0);
        check("reset_flags", {60'd0, zero, taken, ovf, illegal}, 64'd0);
        check("reset_op_count", {48'd0, op_count}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //        gout     a              b              result         z     t     o     i
        tbl[0]  = '{4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{4'b0010, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{4'b0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{4'b1011, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{4'b1110, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{4'b1100, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{4'b1010, 32'h0000_0003, 32'h0000_0004, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{4'b0111, 32'h0000_0012, 32'h0000_0034, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{4'b0100, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{4'b1000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{4'b1001, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{4'b1001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{4'b0010, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{4'b1101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{4'b1111, 32'h0000_0009, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{4'b1011, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0};

        // Latency is counted in samples after the accepting one: out_valid appears on the second.
        for (int i = 0; i < 17; i++) begin
            send_one(tbl[i].g, tbl[i].a, tbl[i].b, r, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
            check($sformatf("vec%0d_result", i), {32'd0, r.result}, {32'd0, tbl[i].r});
            check($sformatf("vec%0d_zero", i), {63'd0, r.zero}, {63'd0, tbl[i].z});
            check($sformatf("vec%0d_taken", i), {63'd0, r.taken}, {63'd0, tbl[i].t});
            check($sformatf("vec%0d_ovf", i), {63'd0, r.ovf}, {63'd0, tbl[i].o});
            check($sformatf("vec%0d_illegal", i), {63'd0, r.illegal}, {63'd0, tbl[i].i});
        end
        @(negedge clk); #1;
        check("table_op_count", {48'd0, op_count}, 64'd17);

        stall_burst();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            gout      = 4'($urandom_range(0, 15));
            a         = pick_operand();
            b         = pick_operand();
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("random_drain_empty", 64'(exp_q.size()), 64'd0);

        // Fill S1 and S2, then pulse reset between clock edges.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; gout = 4'b0000; a = 32'd10; b = 32'd20;
        @(negedge clk);
        a = 32'd30; b = 32'd40;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        check("full_out_valid", {63'd0, out_valid}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        check("midreset_op_count", {48'd0, op_count}, 64'd0);
        check("midreset_result", {32'd0, result}, 64'd0);
        check("midreset_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; gout = 4'b0000; a = 32'd2; b = 32'd3; out_ready = 1'b1;
        #1;
        check("release_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("release_no_stale", {63'd0, out_valid}, 64'd0);
        @(negedge clk); #1;
        check("release_out_valid", {63'd0, out_valid}, 64'd1);
        check("release_result", {32'd0, result}, 64'd5);
        @(negedge clk); #1;
        check("release_op_count", {48'd0, op_count}, 64'd1);

        // Run 65538 back-to-back responses from a fresh reset so op_count wraps to 2.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acc = 0; cons = 0;
        for (int cyc = 0; cyc < 70000 && cons < 65538; cyc++) begin
            @(negedge clk);
            in_valid  = (acc < 65538);
            out_ready = 1'b1;
            gout      = 4'($urandom_range(0, 15));
            a         = $urandom;
            b         = $urandom;
            #1;
            if (out_valid && out_ready) cons++;
            if (in_valid && in_ready) acc++;
        end
        check("wrap_consumed", 64'(cons), 64'd65538);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("wrap_op_count", {48'd0, op_count}, 64'd2);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
